// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared FSM state type and default widths for the burst controller.
package mem_burst_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 8;
  localparam int LEN_W_DEF  = 4;
endpackage

// File: rtl/mem_rsp_fifo.sv
// mem_rsp_fifo: 2-entry response FIFO with occupancy count; never pushed when full.
module mem_rsp_fifo #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
  end
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst read/write controller for a 1-cycle-latency memory; MEM_BURST_ERR_EN rejects bursts past the top address.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_wr,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wdata_valid,
  output logic              o_wdata_ready,
  input  logic [DATA_W-1:0] i_wdata,
  output logic              o_rdata_valid,
  input  logic              i_rdata_ready,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_last,
  output logic              o_mem_wr_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy,
  output logic              o_err
);
  state_t state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W:0] count;
  logic inflight, inflight_last, hs, pop, issue, bad, fifo_last;
  logic [1:0] fifo_count;
  logic [DATA_W-1:0] fifo_data;
  assign hs = i_cmd_valid && o_cmd_ready;
`ifdef MEM_BURST_ERR_EN
  logic [ADDR_W:0] end_addr;
  assign end_addr = {1'b0, i_cmd_addr} + {{(ADDR_W+1-LEN_W){1'b0}}, i_cmd_len};
  assign bad = end_addr[ADDR_W];
`else
  assign bad = 1'b0;
`endif
  assign o_cmd_ready = rst_n && state == IDLE;
  assign o_busy = state != IDLE;
  assign o_wdata_ready = state == WRITE;
  assign o_mem_wr_en = state == WRITE && i_wdata_valid;
  assign o_mem_addr = addr;
  assign o_mem_data = state == WRITE ? i_wdata : '0;
  assign o_rdata_valid = fifo_count != 2'd0;
  assign o_rdata = fifo_data;
  assign o_rdata_last = o_rdata_valid && fifo_last;
  assign pop = o_rdata_valid && i_rdata_ready;
  // Keep buffered plus outstanding reads within the two FIFO slots.
  assign issue = state == READ && count != '0 &&
                 (3'(fifo_count) + 3'(inflight)) < (3'd2 + 3'(pop));
  mem_rsp_fifo #(.W(DATA_W + 1)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (inflight),
    .din   ({inflight_last, i_mem_data}),
    .pop   (pop),
    .dout  ({fifo_last, fifo_data}),
    .count (fifo_count)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      count <= '0;
      inflight <= 1'b0;
      inflight_last <= 1'b0;
      o_err <= 1'b0;
    end else begin
      o_err <= 1'b0;
      inflight <= issue;
      inflight_last <= issue && count == (LEN_W+1)'(1);
      case (state)
        IDLE: if (hs) begin
          if (bad) o_err <= 1'b1;
          else begin
            addr <= i_cmd_addr;
            count <= {1'b0, i_cmd_len} + (LEN_W+1)'(1);
            state <= i_cmd_wr ? WRITE : READ;
          end
        end
        WRITE: if (i_wdata_valid) begin
          addr <= addr + ADDR_W'(1);
          count <= count - (LEN_W+1)'(1);
          if (count == (LEN_W+1)'(1)) state <= IDLE;
        end
        READ: begin
          if (issue) begin
            addr <= addr + ADDR_W'(1);
            count <= count - (LEN_W+1)'(1);
          end
          if (pop && fifo_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: random bursts against a reference memory image with cycle-level stream checks.
module tb_mem_burst_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic i_cmd_valid = 1'b0, o_cmd_ready, i_cmd_wr = 1'b0;
  logic [7:0] i_cmd_addr = '0;
  logic [3:0] i_cmd_len = '0;
  logic i_wdata_valid = 1'b0, o_wdata_ready;
  logic [31:0] i_wdata = '0;
  logic o_rdata_valid, i_rdata_ready = 1'b0, o_rdata_last;
  logic [31:0] o_rdata;
  logic o_mem_wr_en;
  logic [7:0] o_mem_addr;
  logic [31:0] o_mem_data, i_mem_data = '0;
  logic o_busy, o_err;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  int vectors = 0, miscompares = 0;

  mem_burst_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_wr(i_cmd_wr), .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
    .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
    .o_rdata_last(o_rdata_last), .o_mem_wr_en(o_mem_wr_en), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .i_mem_data(i_mem_data), .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_mem_wr_en) mem[o_mem_addr] <= o_mem_data;
    i_mem_data <= mem[o_mem_addr];
  end

  task automatic send_cmd(input bit wr, input logic [7:0] a, input logic [3:0] len);
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = a; i_cmd_len = len;
    #1;
    vectors++;
    if (o_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_ready: got %b want 1", o_cmd_ready);
    end
    @(posedge clk);
    #1 i_cmd_valid = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    #1;
    vectors++;
    if (o_busy !== 1'b0 || o_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s idle: busy=%b ready=%b want 0/1", tag, o_busy, o_cmd_ready);
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++;
    if (o_cmd_ready !== 1'b0 || o_busy !== 1'b0 || o_rdata_valid !== 1'b0 || o_err !== 1'b0 ||
        o_mem_wr_en !== 1'b0 || o_mem_addr !== 8'h0 || o_rdata_last !== 1'b0 || o_wdata_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset outputs: ready=%b busy=%b rv=%b err=%b we=%b addr=%h want all 0",
               o_cmd_ready, o_busy, o_rdata_valid, o_err, o_mem_wr_en, o_mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (o_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset release ready: got %b want 1", o_cmd_ready);
    end
  endtask

  task automatic test_idle_beat;
    @(negedge clk);
    i_wdata_valid = 1'b1; i_wdata = 32'hDEAD_BEEF;
    #1;
    vectors++;
    if (o_mem_wr_en !== 1'b0 || o_wdata_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL idle beat: we=%b wready=%b want 0/0", o_mem_wr_en, o_wdata_ready);
    end
    @(posedge clk);
    #1 i_wdata_valid = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [3:0] len, input bit bub, input logic [31:0] base);
    int b = 0, t = 0;
    logic v;
    logic [31:0] d;
    send_cmd(1'b1, a, len);
    while (b <= int'(len) && t < 200) begin
      @(negedge clk);
      t++;
      v = bub ? 1'($urandom % 2) : 1'b1;
      d = bub ? $urandom : base + 32'(b);
      i_wdata_valid = v; i_wdata = d;
      #1;
      vectors++;
      if (o_mem_wr_en !== v || (v && (o_mem_addr !== 8'(int'(a) + b) || o_mem_data !== d))) begin
        miscompares++;
        $display("FAIL write beat %0d: we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                 b, o_mem_wr_en, o_mem_addr, o_mem_data, v, 8'(int'(a) + b), d);
      end
      if (v) begin
        ref_mem[8'(int'(a) + b)] = d;
        b++;
      end
      @(posedge clk);
    end
    #1 i_wdata_valid = 1'b0;
    if (t >= 200) begin
      vectors++; miscompares++;
      $display("FAIL write timeout: beats %0d want %0d", b, int'(len) + 1);
    end
    check_idle("write");
  endtask

  task automatic do_read(input logic [7:0] a, input logic [3:0] len, input int mode);
    int k = 0, t = 0;
    bit r;
    send_cmd(1'b0, a, len);
    while (k <= int'(len) && t < 300) begin
      @(negedge clk);
      t++;
      r = mode == 0 ? 1'b1 : mode == 1 ? (t % 2 == 1) : 1'($urandom % 2);
      i_rdata_ready = r;
      #1;
      if (mode == 0) begin
        vectors++;
        if (o_rdata_valid !== (t >= 3 && t <= int'(len) + 3)) begin
          miscompares++;
          $display("FAIL read timing cycle %0d: valid=%b want %b", t, o_rdata_valid, t >= 3 && t <= int'(len) + 3);
        end
      end
      if (o_rdata_valid === 1'b1) begin
        vectors++;
        if (o_rdata !== ref_mem[8'(int'(a) + k)] || o_rdata_last !== (k == int'(len)) || o_mem_wr_en !== 1'b0) begin
          miscompares++;
          $display("FAIL read beat %0d: data=%h last=%b we=%b want data=%h last=%b we=0",
                   k, o_rdata, o_rdata_last, o_mem_wr_en, ref_mem[8'(int'(a) + k)], k == int'(len));
        end
        if (r) k++;
      end
      @(posedge clk);
    end
    #1 i_rdata_ready = 1'b0;
    if (t >= 300) begin
      vectors++; miscompares++;
      $display("FAIL read timeout: beats %0d want %0d", k, int'(len) + 1);
    end
    check_idle("read");
  endtask

  task automatic test_directed;
    do_write(8'h10, 4'd3, 1'b0, 32'hA0);
    do_read(8'h10, 4'd3, 0);
    do_read(8'h40, 4'd15, 0);
    do_read(8'h60, 4'd7, 1);
  endtask

  task automatic test_wrap;
`ifdef MEM_BURST_ERR_EN
    logic [31:0] keep;
    keep = ref_mem[8'hFE];
    send_cmd(1'b1, 8'hFE, 4'd3);
    @(negedge clk);
    i_wdata_valid = 1'b1; i_wdata = 32'h1234_5678;
    #1;
    vectors++;
    if (o_err !== 1'b1 || o_busy !== 1'b0 || o_cmd_ready !== 1'b1 || o_mem_wr_en !== 1'b0) begin
      miscompares++;
      $display("FAIL err pulse: err=%b busy=%b ready=%b we=%b want 1/0/1/0", o_err, o_busy, o_cmd_ready, o_mem_wr_en);
    end
    @(negedge clk);
    #1;
    vectors++;
    if (o_err !== 1'b0 || o_mem_wr_en !== 1'b0 || mem[8'hFE] !== keep) begin
      miscompares++;
      $display("FAIL err after: err=%b we=%b mem=%h want 0/0/%h", o_err, o_mem_wr_en, mem[8'hFE], keep);
    end
    i_wdata_valid = 1'b0;
`else
    do_write(8'hFE, 4'd3, 1'b0, 32'hC0);
    do_read(8'hFE, 4'd3, 0);
    vectors++;
    if (o_err !== 1'b0) begin
      miscompares++;
      $display("FAIL err tied: got %b want 0", o_err);
    end
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++) begin
      logic [3:0] len;
      logic [7:0] a;
      len = 4'($urandom);
      a = 8'($urandom_range(0, 255 - int'(len)));
      do_write(a, len, 1'b1, 32'h0);
      do_read(a, len, 2);
    end
  endtask

  task automatic test_mid_reset;
    send_cmd(1'b0, 8'h20, 4'd15);
    i_rdata_ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    vectors++;
    if (o_rdata_valid !== 1'b1 || o_rdata !== ref_mem[8'h22]) begin
      miscompares++;
      $display("FAIL pre-reset beat: valid=%b data=%h want 1/%h", o_rdata_valid, o_rdata, ref_mem[8'h22]);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_rdata_valid !== 1'b0 || o_busy !== 1'b0 || o_cmd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid reset: valid=%b busy=%b ready=%b want 0/0/0", o_rdata_valid, o_busy, o_cmd_ready);
    end
    i_rdata_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_read(8'h30, 4'd2, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    test_reset;
    test_idle_beat;
    test_directed;
    test_wrap;
    test_random;
    test_mid_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data beat width, equal to the memory word width.
REQ-002 SHALL have parameter ADDR_W, default 8: memory address width (256 words).
REQ-003 SHALL have parameter LEN_W, default 4: burst length field width; beats = i_cmd_len+1 (1..16).
REQ-004 SHALL have ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command offered.
- o_cmd_ready  out  1  command accepted when both are high.
- i_cmd_wr  in  1  1 = write burst, 0 = read burst.
- i_cmd_addr  in  ADDR_W  start address.
- i_cmd_len  in  LEN_W  beats minus one.
- i_wdata_valid / o_wdata_ready / i_wdata  in/out/in  1/1/DATA_W  write beat stream.
- o_rdata_valid / i_rdata_ready / o_rdata / o_rdata_last  out/in/out/out  1/1/DATA_W/1  read beat stream.
- o_mem_wr_en / o_mem_addr / o_mem_data  out  1/ADDR_W/DATA_W  drive the memory write enable, address and data.
- i_mem_data  in  DATA_W  memory read data, valid one cycle after its address.
- o_busy  out  1  high whenever the state is not IDLE.
- o_err  out  1  one-cycle error pulse.

Function
REQ-005 SHALL implement FSM states IDLE, WRITE, READ; o_cmd_ready = (state==IDLE).
REQ-006 On a command handshake, SHALL latch addr, beat count = len+1 and op, then enter WRITE or READ on the next cycle.
REQ-007 In WRITE: o_wdata_ready=1; o_mem_wr_en = i_wdata_valid, combinational; o_mem_addr = current addr; o_mem_data = i_wdata.
REQ-008 Each accepted write beat SHALL increment addr and decrement count; after the last beat the FSM SHALL return to IDLE on the next edge.
REQ-009 Write bubbles (i_wdata_valid=0) SHALL leave o_mem_wr_en=0 with no other effect.
REQ-010 In READ, o_mem_wr_en SHALL be 0. A read is issued in a cycle if beats remain to issue and (fifo_count + inflight − pop) < 2. On issue, addr increments and the inflight flag is set for one cycle.
REQ-011 Data for an inflight read SHALL be pushed from i_mem_data into a 2-entry response FIFO on the following edge; i_mem_data SHALL be ignored in all other cycles.
REQ-012 o_rdata_valid = FIFO non-empty; o_rdata = FIFO head; pop on valid&ready; o_rdata_last SHALL mark the final beat of the burst.
REQ-013 With i_rdata_ready held high, the read stream SHALL sustain 1 beat/cycle; the first o_rdata_valid SHALL occur 3 cycles after the command handshake cycle.
REQ-014 i_rdata_ready=0 SHALL stall issue without losing or duplicating beats.
REQ-015 READ SHALL exit to IDLE on the edge where the last beat pops.
REQ-016 Address arithmetic is modulo 2^ADDR_W (255 wraps to 0) unless REQ-021 applies.
REQ-017 A write beat presented while in IDLE SHALL NOT be accepted; it waits for the WRITE state.

Reset
REQ-018 rst_n low SHALL, immediately and asynchronously, force: state IDLE, FIFO empty, inflight 0, addr/count 0.
REQ-019 Reset values: o_cmd_ready=1 once rst_n is released, and 0 while rst_n is low; all other outputs 0.
REQ-020 Reset mid-burst SHALL abort the burst; remaining beats are never issued.

Configuration
REQ-021 With MEM_BURST_ERR_EN defined, a command whose addr+len exceeds 2^ADDR_W−1 SHALL be accepted with no memory access and no write beats consumed; o_err pulses for one cycle and the FSM stays in IDLE.
REQ-022 With MEM_BURST_ERR_EN undefined, such bursts SHALL wrap and o_err SHALL be tied 0.

Structure
REQ-023 Package mem_burst_pkg SHALL hold the state enum and the default width constants.
REQ-024 The response FIFO SHALL be sub-module mem_rsp_fifo (2 entries, DATA_W+1 wide, with its own count).

Verification
REQ-025 Write addr 0x10, len 3, data 0xA0..0xA3, then read the same → o_mem_wr_en high 4 cycles at 0x10..0x13; read returns 0xA0..0xA3 with last on 0xA3.
REQ-026 Read len 15 with ready always high → 16 beats on consecutive cycles, first valid 3 cycles after the handshake.
REQ-027 Read len 7 with ready toggling 1/0 each cycle → 8 beats in order, no drops or duplicates, at most 2 buffered.
REQ-028 Write addr 0xFE, len 3 → without macro, writes land at 0xFE, 0xFF, 0x00, 0x01; with MEM_BURST_ERR_EN, a single o_err pulse, no writes, and o_cmd_ready high the next cycle.
REQ-029 rst_n low during the 3rd beat of a 16-beat read → o_rdata_valid=0 and o_busy=0 at once; a new command is accepted after release.
